// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: entry type, frame lengths and entry packing helper for spi_rx.
// Values come from the shared spi_defs.vh header.
package spi_rx_pkg;
`include "spi_defs.vh"

  localparam int ENTRY_W = `SPI_ENTRY_W;
  localparam int BITS8   = `SPI_BITS8;
  localparam int BITS16  = `SPI_BITS16;

  typedef struct packed {
    logic        wide;
    logic        cdn;
    logic [15:0] payload;
  } entry_t;

  // Pack through the header field positions so the layout stays in step
  // with the master side.
  function automatic entry_t mk_entry(logic wide, logic cdn, logic [15:0] payload);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[`SPI_WIDE_BIT] = wide;
    e[`SPI_CDN_BIT]  = cdn;
    e[`SPI_PAYLOAD_MSB:`SPI_PAYLOAD_LSB] = payload;
    return entry_t'(e);
  endfunction
endpackage

// File: rtl/spi_rx_if.sv
// spi_rx_if: SPI pins plus the CPU-side read/status port of spi_rx.
//   master : SPI master / CPU side (drives pins, rd_en, clr_err)
//   slave  : spi_rx side (drives rd_* and error flags)
interface spi_rx_if #(parameter int LW = 3);
  logic          spi_sck;
  logic          spi_mosi;
  logic          spi_cdn;
  logic          spi_cen;
  logic          rd_en;
  logic          clr_err;
  logic [15:0]   rd_data;
  logic          rd_cdn;
  logic          rd_wide;
  logic          rd_valid;
  logic [LW-1:0] rd_level;
  logic          ovr_err;
  logic          frm_err;

  modport master (
    output spi_sck, spi_mosi, spi_cdn, spi_cen, rd_en, clr_err,
    input  rd_data, rd_cdn, rd_wide, rd_valid, rd_level, ovr_err, frm_err
  );
  modport slave (
    input  spi_sck, spi_mosi, spi_cdn, spi_cen, rd_en, clr_err,
    output rd_data, rd_cdn, rd_wide, rd_valid, rd_level, ovr_err, frm_err
  );
endinterface

// File: rtl/spi_defs.vh
// Shared SPI definitions, included by the SPI master and by spi_rx.
// Entry layout of one received word: payload [15:0], cdn [16], wide [17].
`ifndef SPI_DEFS_VH
`define SPI_DEFS_VH
`define SPI_ENTRY_W     18
`define SPI_PAYLOAD_MSB 15
`define SPI_PAYLOAD_LSB 0
`define SPI_CDN_BIT     16
`define SPI_WIDE_BIT    17
`define SPI_BITS8       8
`define SPI_BITS16      16
`endif

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: synchronous show-ahead FIFO with level counter.
// Ports: clk, rst (async, high); i_push/i_push_data write; i_pop read;
//   o_head head entry (holds last value when empty); o_valid not empty;
//   o_level occupancy; o_drop pulses when a push is lost to a full FIFO.
module spi_rx_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 18,
  parameter int LW      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_push_data,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head,
  output logic               o_valid,
  output logic [LW-1:0]      o_level,
  output logic               o_drop
);
  localparam int PW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr, r_rd_ptr, w_rd_ptr_n;
  logic [LW-1:0]      r_level, w_level_n;
  logic [ENTRY_W-1:0] r_head;
  logic               w_pop, w_push, w_full;

  assign w_full = (r_level == LW'(DEPTH));
  assign w_pop  = i_pop && (r_level != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = i_push && (!w_full || w_pop);
  assign o_drop = i_push && !w_push;

  assign w_rd_ptr_n = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;

  always_comb begin
    w_level_n = r_level;
    if (w_push && !w_pop)      w_level_n = r_level + LW'(1);
    else if (!w_push && w_pop) w_level_n = r_level - LW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_ptr_n;
      r_level  <= w_level_n;
      // Head register: follows the next head slot; when that slot is the
      // one being written this cycle, bypass the incoming entry. Left
      // untouched when the FIFO goes empty so the last value is held.
      if (w_level_n != '0)
        r_head <= (w_push && (r_wr_ptr == w_rd_ptr_n)) ? i_push_data : r_mem[w_rd_ptr_n];
    end
  end

  assign o_head  = r_head;
  assign o_valid = (r_level != '0);
  assign o_level = r_level;
endmodule

// File: rtl/spi_rx.sv
// spi_rx: mode-0 SPI peripheral receiver feeding a CPU-readable FIFO.
// Ports: clk, rst (async, high); bus (spi_rx_if.slave) carrying the SPI
//   pins spi_sck/spi_mosi/spi_cdn/spi_cen and the read port rd_en, clr_err,
//   rd_data, rd_cdn, rd_wide, rd_valid, rd_level, ovr_err, frm_err.
// Build option: define SPI_RX_LSBFIRST_EN to receive bits LSB first.
import spi_rx_pkg::*;

module spi_rx #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic     clk,
  input  logic     rst,
  spi_rx_if.slave  bus
);
  // [0],[1] synchronizer, [2] previous value for edge detection.
  logic [2:0]  r_sck_sync, r_cen_sync;
  logic [1:0]  r_mosi_sync, r_cdn_sync;
  logic [15:0] r_shift;
  logic [3:0]  r_count;
  logic        r_tag;
  logic        r_ovr, r_frm;

  logic        w_sck_rise, w_cen_s, w_cen_rise, w_cen_fall;
  logic        w_mosi_s, w_cdn_s, w_bit_en;
  logic        w_push16, w_push8, w_push, w_frm_evt, w_drop;
  logic [15:0] w_shift_n, w_byte;
  entry_t      w_push_entry, w_head;
  logic [ENTRY_W-1:0] w_head_raw;
  logic        w_unused_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_cen_sync  <= '1;   // idle after reset: a frame needs a fresh cen fall
      r_mosi_sync <= '0;
      r_cdn_sync  <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], bus.spi_sck};
      r_cen_sync  <= {r_cen_sync[1:0], bus.spi_cen};
      r_mosi_sync <= {r_mosi_sync[0], bus.spi_mosi};
      r_cdn_sync  <= {r_cdn_sync[0], bus.spi_cdn};
    end
  end

  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_cen_s    = r_cen_sync[1];
  assign w_cen_rise = r_cen_sync[1] & ~r_cen_sync[2];
  assign w_cen_fall = ~r_cen_sync[1] & r_cen_sync[2];
  assign w_mosi_s   = r_mosi_sync[1];
  assign w_cdn_s    = r_cdn_sync[1];
  assign w_bit_en   = w_sck_rise && !w_cen_s;

`ifdef SPI_RX_LSBFIRST_EN
  assign w_shift_n    = {w_mosi_s, r_shift[15:1]};
  assign w_byte       = {8'h00, r_shift[15:8]};
  assign w_unused_bit = r_shift[0];
`else
  assign w_shift_n    = {r_shift[14:0], w_mosi_s};
  assign w_byte       = {8'h00, r_shift[7:0]};
  assign w_unused_bit = r_shift[15];
`endif

  // 16th bit pushes immediately; a byte is only known complete at cen rise.
  assign w_push16  = w_bit_en && (r_count == 4'(BITS16 - 1));
  assign w_push8   = w_cen_rise && (r_count == 4'(BITS8));
  assign w_frm_evt = w_cen_rise && (r_count != 4'd0) && (r_count != 4'(BITS8));
  assign w_push    = w_push16 || w_push8;
  assign w_push_entry = w_push16 ? mk_entry(1'b1, w_cdn_s, w_shift_n)
                                 : mk_entry(1'b0, r_tag, w_byte);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_count <= '0;
      r_tag   <= 1'b0;
    end else begin
      if (w_cen_s || w_cen_fall) begin
        r_count <= '0;
      end else if (w_bit_en) begin
        r_count <= r_count + 4'd1;   // 15 -> 0 wraps for back-to-back words
        r_shift <= w_shift_n;
        if (r_count == 4'(BITS8 - 1)) r_tag <= w_cdn_s;
      end
    end
  end

  // Sticky flags: a new error in the clr_err cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovr <= 1'b0;
      r_frm <= 1'b0;
    end else begin
      if (w_drop)           r_ovr <= 1'b1;
      else if (bus.clr_err) r_ovr <= 1'b0;
      if (w_frm_evt)        r_frm <= 1'b1;
      else if (bus.clr_err) r_frm <= 1'b0;
    end
  end

  spi_rx_fifo #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .LW(LW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_data(w_push_entry),
    .i_pop      (bus.rd_en),
    .o_head     (w_head_raw),
    .o_valid    (bus.rd_valid),
    .o_level    (bus.rd_level),
    .o_drop     (w_drop)
  );

  assign w_head      = entry_t'(w_head_raw);
  assign bus.rd_data = w_head.payload;
  assign bus.rd_cdn  = w_head.cdn;
  assign bus.rd_wide = w_head.wide;
  assign bus.ovr_err = r_ovr;
  assign bus.frm_err = r_frm;
endmodule

// File: doc/spi_rx.md
Name: spi_rx

Overview:
- SPI peripheral receiver: the far end of the existing transmit-only SPI master (spi_mosi, spi_sck, spi_cdn, spi_cen).
- Mode 0: sck idles low, MOSI sampled on the sck rising edge.
- Samples the four SPI pins in the clk domain and assembles 8-bit command/data bytes and 16-bit data words.
- Queues each received word with its command/data tag in a small FIFO that the Hack CPU reads through memory-mapped registers.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- LW, 3, width of rd_level; equals log2(DEPTH)+1.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-high reset
- spi_sck  in  1  SPI clock from the master; asynchronous to clk
- spi_mosi  in  1  serial data, MSB first
- spi_cdn  in  1  0 = command, 1 = data
- spi_cen  in  1  chip enable, active low; frames one transfer
- rd_en  in  1  pop the head entry
- clr_err  in  1  clear the sticky error flags
- rd_data  out  16  head entry payload; an 8-bit word is zero-extended
- rd_cdn  out  1  head entry command/data tag
- rd_wide  out  1  head entry is a 16-bit word
- rd_valid  out  1  FIFO not empty
- rd_level  out  LW  number of occupied entries
- ovr_err  out  1  sticky: a word was dropped because the FIFO was full
- frm_err  out  1  sticky: a frame ended on a bit count other than 0, 8 or 16

Behaviour:
- Reset: the design uses one clock (clk) and an asynchronous, active-high reset (rst). Asserting rst immediately clears all state: FIFO empty, rd_valid=0, rd_level=0, rd_data=0, rd_cdn=0, rd_wide=0, ovr_err=0, frm_err=0, bit count 0, shift register 0, all synchronizers 0 except cen_s=1.
- Input sync: each SPI pin passes through a 2-flop synchronizer, then a third "previous" flop for edge detection.
  - Events are detected combinationally from stages 2 and 3; the resulting action is registered on the next clk edge.
  - Fixed latency: the action lands on the 3rd rising clk edge after the pin transition, counting the first edge that samples the new level.
- Timing requirement on the master: sck high time and low time are each at least 3 clk cycles. Setup of mosi/cdn before the sck rising edge is at least 1 clk cycle.
- Receive states:
  - IDLE: cen_s=1; bit count held at 0; sck edges are ignored.
  - SHIFT: cen_s=0.
- On each sck rising edge in SHIFT:
  - shift <= {shift[14:0], mosi_s}; count++.
  - cdn_s is latched as the word tag on the 8th and on the 16th bit.
- count reaches 16: the word is pushed in the same cycle as the 16th sample, with wide=1 and payload {shift[14:0], mosi_s}. count returns to 0, so continuous 16-bit streaming works while cen stays low.
- cen rising edge (SHIFT→IDLE):
  - count==8: push payload {8'h00, shift[7:0]}, wide=0, tag from the 8th bit.
  - count==0: nothing.
  - any other count: no push; frm_err <= 1.
  - count is cleared in every case.
- A cen falling edge clears count; a frame always starts aligned.
- FIFO behaviour:
  - Show-ahead: rd_data, rd_cdn and rd_wide always reflect the head entry. When the FIFO is empty they hold their last value (0 after reset).
  - Pop occurs when rd_en && rd_valid; rd_en while empty is ignored.
  - Push into a full FIFO drops the new word and sets ovr_err.
  - Simultaneous push and pop when full: the pop is performed first and the push succeeds; level stays DEPTH and ovr_err is not set.
  - Simultaneous push and pop otherwise: level unchanged.
  - Pointers wrap modulo DEPTH.
- Errors: clr_err clears both flags on the next edge. If a new error event occurs in the same cycle as clr_err, the error wins and the flag stays 1.
- Reset mid-frame: the partial word is discarded. Receive then resumes at the next cen falling edge, because cen_s resets to 1.

Optional Feature:
- Macro: SPI_RX_LSBFIRST_EN.
- Defined: bits are received LSB first.
  - Shift rule: shift <= {mosi_s, shift[15:1]}.
  - A 16-bit word pushes {mosi_s, shift[15:1]}.
  - An 8-bit word pushes {8'h00, shift[15:8]}.
- Undefined: MSB first, as described in Behaviour. All other behaviour is identical.

Decomposition:
- Shared header spi_defs.vh holds:
  - ENTRY_W=18 and the entry field positions: payload [15:0], cdn [16], wide [17].
  - Frame lengths BITS8=8 and BITS16=16.
- The same header is also included by the existing spi master.
- One sub-module, spi_rx_fifo:
  - Parameterised DEPTH/ENTRY_W synchronous FIFO with show-ahead output, level counter and full-push drop indication.
  - Same asynchronous active-high reset.

Test Plan:
- Master sends command byte 0xA5 (cdn=0, 8 sck pulses, then cen high) → rd_valid rises on the 3rd clk edge after cen rise; rd_data=0x00A5, rd_cdn=0, rd_wide=0, rd_level=1.
- Master sends D16 0x1234 then 0xBEEF (cdn=1) in one cen frame → two entries: 0x1234 then 0xBEEF, both wide=1, cdn=1. Pop twice → rd_valid=0.
- Master sends DEPTH+1 = 5 bytes with no pops → rd_level=4; ovr_err=1; head entry is still the 1st byte. clr_err → ovr_err=0.
- Master sends 5 sck pulses, then cen high → no push; frm_err=1. A following byte 0x3C is received correctly.
- rst asserted after 4 bits of a frame → outputs clear immediately. Next full frame 0x81 → rd_data=0x0081.
- FIFO full, with a push and rd_en in the same cycle → level stays 4; ovr_err stays 0; the new word becomes the last entry.
